// File: rtl/bht_pkg.sv
// Shared definitions for the gshare/bimodal branch history table:
// counter encodings, controller states and default geometry.
package bht_pkg;

  localparam int DEF_INDEX_BITS = 8;
  localparam int DEF_GHR_BITS   = 8;
  localparam int DEF_MODE       = 1;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/bht_gshare_sat_ctr2.sv
// Two-bit saturating counter next-state: taken counts up to ST,
// not-taken counts down to SNT.
module sat_ctr2
  import bht_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != 2'(ST)) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != 2'(SNT)) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/bht_gshare.sv
// Branch history table of 2-bit counters with bimodal or gshare indexing,
// speculative global history and a power-up sweep that seeds every entry.
module bht_gshare
  import bht_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int GHR_BITS   = DEF_GHR_BITS,
  parameter int MODE       = DEF_MODE
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                lk_valid,
  input  logic [31:0]         lk_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [1:0]          pred_ctr,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic                upd_mispredict
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS:0] LAST_IDX = (INDEX_BITS+1)'(DEPTH - 1);

  state_e                state_q;
  logic [INDEX_BITS:0]   init_cnt_q;
  logic                  ready_q;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic                  pred_valid_q, pred_taken_q;
  logic [1:0]            pred_ctr_q;
  logic [GHR_BITS-1:0]   pred_ghr_q;

  logic [1:0]            tbl_q [DEPTH];

  logic                  lk_acc, upd_acc;
  logic [INDEX_BITS-1:0] lk_idx, upd_idx;
  logic [1:0]            upd_ctr, upd_next, lk_ctr;
  logic [GHR_BITS:0]     restore_hist, spec_hist;
  logic                  unused_bits;

  assign lk_acc  = lk_valid  & ready_q;
  assign upd_acc = upd_valid & ready_q;

  generate
    if (MODE == 1) begin : g_gshare
      assign lk_idx  = lk_pc[INDEX_BITS+1:2]  ^ INDEX_BITS'(ghr_q);
      assign upd_idx = upd_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(upd_ghr);
    end else begin : g_bimodal
      assign lk_idx  = lk_pc[INDEX_BITS+1:2];
      assign upd_idx = upd_pc[INDEX_BITS+1:2];
    end
  endgenerate

  assign unused_bits = ^{lk_pc[1:0], upd_pc[1:0], lk_pc[31:INDEX_BITS+2],
                         upd_pc[31:INDEX_BITS+2], upd_ghr};

  assign upd_ctr = tbl_q[upd_idx];

  sat_ctr2 u_sat (
    .ctr_i   (upd_ctr),
    .taken_i (upd_taken),
    .ctr_o   (upd_next)
  );

  // A same-cycle update to the looked-up entry is forwarded so the
  // prediction never sees a stale counter.
  assign lk_ctr = (upd_acc && (upd_idx == lk_idx)) ? upd_next : tbl_q[lk_idx];

  // Concatenate-then-truncate keeps the shift legal for a 1-bit history.
  assign restore_hist = {upd_ghr, upd_taken};
  assign spec_hist    = {ghr_q, lk_ctr[1]};

  always_comb begin
    ghr_d = ghr_q;
    if (MODE == 1) begin
      if (upd_acc && upd_mispredict) ghr_d = restore_hist[GHR_BITS-1:0];
      else if (lk_acc)               ghr_d = spec_hist[GHR_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      ready_q      <= 1'b0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ctr_q   <= 2'b00;
      pred_ghr_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + (INDEX_BITS+1)'(1);
          if (init_cnt_q == LAST_IDX) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN:     ready_q <= 1'b1;
        default: state_q <= INIT;
      endcase
      ghr_q        <= ghr_d;
      pred_valid_q <= lk_acc;
      if (lk_acc) begin
        pred_taken_q <= lk_ctr[1];
        pred_ctr_q   <= lk_ctr;
        pred_ghr_q   <= ghr_q;
      end
    end
  end

  // Table contents survive reset; the init sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (state_q == INIT) tbl_q[init_cnt_q[INDEX_BITS-1:0]] <= 2'(WNT);
    else if (upd_acc)    tbl_q[upd_idx] <= upd_next;
  end

  assign ready      = ready_q;
  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_ctr   = pred_ctr_q;
  assign pred_ghr   = pred_ghr_q;

endmodule

// File: tb/tb_bht_gshare.sv
// Directed bench for bht_gshare (16 entries, 4-bit history, gshare):
// expected predictions are queued at drive time and popped on pred_valid.
module tb_bht_gshare;

  localparam int IB = 4;
  localparam int GB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ready;
  logic          lk_valid = 1'b0;
  logic [31:0]   lk_pc = '0;
  logic          pred_valid, pred_taken;
  logic [1:0]    pred_ctr;
  logic [GB-1:0] pred_ghr;
  logic          upd_valid = 1'b0;
  logic [31:0]   upd_pc = '0;
  logic [GB-1:0] upd_ghr = '0;
  logic          upd_taken = 1'b0;
  logic          upd_mispredict = 1'b0;

  typedef struct packed {
    logic [1:0]    ctr;
    logic [GB-1:0] ghr;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  bht_gshare #(.INDEX_BITS(IB), .GHR_BITS(GB), .MODE(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .ready          (ready),
    .lk_valid       (lk_valid),
    .lk_pc          (lk_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_ctr       (pred_ctr),
    .pred_ghr       (pred_ghr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_ghr        (upd_ghr),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    lk_valid = 1'b0;
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  // One clock of stimulus; the prediction (if any) is checked after the edge.
  task automatic step(input logic lk, input logic [31:0] lpc,
                      input logic upd, input logic [31:0] upc,
                      input logic [GB-1:0] ughr, input logic ut, input logic um,
                      input logic [1:0] ectr, input logic [GB-1:0] eghr,
                      input string tag);
    exp_t e;
    lk_valid = lk;  lk_pc = lpc;
    upd_valid = upd; upd_pc = upc; upd_ghr = ughr;
    upd_taken = ut; upd_mispredict = um;
    if (lk) sb_q.push_back('{ctr: ectr, ghr: eghr});
    @(posedge clk); #1;
    idle();
    check({tag, ".valid"}, 32'(pred_valid), 32'(lk));
    if (pred_valid) begin
      check({tag, ".sb"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("txn %s: ctr=%0d taken=%0d ghr=%0h", tag, pred_ctr, pred_taken, pred_ghr);
        check({tag, ".ctr"},   32'(pred_ctr),   32'(e.ctr));
        check({tag, ".taken"}, 32'(pred_taken), 32'(e.ctr[1]));
        check({tag, ".ghr"},   32'(pred_ghr),   32'(e.ghr));
      end
    end
  endtask

  // Count edges from reset release until ready; optionally hammer the
  // request ports to prove they are ignored during the sweep.
  task automatic wait_init(input bit pulse);
    int  cycles;
    bit  done;
    cycles = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (pulse) begin
        lk_valid = 1'b1; lk_pc = 32'h0;
        upd_valid = 1'b1; upd_pc = 32'h0; upd_ghr = '0; upd_taken = 1'b1;
      end
      @(posedge clk); #1;
      cycles++;
      if (pulse) check("init.pred_valid", 32'(pred_valid), 32'd0);
      if (ready) done = 1;
    end
    idle();
    $display("txn init: ready after %0d cycles", cycles);
    check("init.len", 32'(cycles), 32'd16);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++)
      step(1'b1, 32'(i << 2), 1'b0, 32'h0, '0, 1'b0, 1'b0, 2'b01, 4'h0, tag);
  endtask

  initial begin
    idle();
    #3;
    check("rst.ready",      32'(ready),      32'd0);
    check("rst.pred_valid", 32'(pred_valid), 32'd0);
    check("rst.pred_taken", 32'(pred_taken), 32'd0);
    check("rst.pred_ctr",   32'(pred_ctr),   32'd0);
    check("rst.pred_ghr",   32'(pred_ghr),   32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    wait_init(1'b1);
    sweep("sweep1");

    // Saturation up and down at PC 0x40 (index 0).
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 1'b1, 32'h40, 4'h0, 1'b1, 1'b0, 2'b00, 4'h0, "upd_t");
    step(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b11, 4'h0, "sat_hi");
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 1'b1, 32'h40, 4'h0, 1'b0, 1'b0, 2'b00, 4'h0, "upd_nt");
    step(1'b1, 32'h44, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b00, 4'h1, "sat_lo");
    step(1'b0, 32'h0, 1'b1, 32'h40, 4'h0, 1'b0, 1'b0, 2'b00, 4'h0, "upd_nt5");
    step(1'b1, 32'h48, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b00, 4'h2, "sat_lo2");

    // Same-cycle update and lookup both hitting index 5.
    step(1'b1, 32'h04, 1'b1, 32'h14, 4'h0, 1'b1, 1'b0, 2'b10, 4'h4, "bypass");

    // Mispredict restore to zero history, then three taken lookups.
    step(1'b0, 32'h0, 1'b1, 32'h3C, 4'h0, 1'b0, 1'b1, 2'b00, 4'h0, "restore0");
    step(1'b1, 32'h14, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b10, 4'h0, "spec1");
    step(1'b1, 32'h10, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b10, 4'h1, "spec2");
    step(1'b1, 32'h18, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b10, 4'h3, "spec3");
    step(1'b1, 32'h1C, 1'b1, 32'h14, 4'h5, 1'b0, 1'b1, 2'b00, 4'h7, "ghr7_misp");
    step(1'b1, 32'h28, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b00, 4'hA, "ghrA");

    // Reset mid-RUN while a prediction is on the outputs.
    step(1'b1, 32'h28, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b01, 4'h4, "pre_rst");
    rst = 1'b0;
    #1;
    check("rst2.pred_valid", 32'(pred_valid), 32'd0);
    check("rst2.ready",      32'(ready),      32'd0);
    check("rst2.pred_ctr",   32'(pred_ctr),   32'd0);
    check("rst2.pred_ghr",   32'(pred_ghr),   32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    wait_init(1'b0);
    sweep("sweep2");

    check("sb.empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
